// File: rtl/rs_tx_framer_pkg.sv
// rs_tx_framer_pkg: shared types and defaults for the RS232C byte-stream framer.
// The checksum trailer exists only when RS_TX_FRAMER_CKSUM_EN is defined.
package rs_tx_framer_pkg;

    localparam int         LEN_W_DEF = 24;
    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    // Main frame sequencer states
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HDR0 = 4'd1,
        HDR1 = 4'd2,
        LEN2 = 4'd3,
        LEN1 = 4'd4,
        LEN0 = 4'd5,
        PAY  = 4'd6,
`ifdef RS_TX_FRAMER_CKSUM_EN
        CKS  = 4'd7,
`endif
        FIN  = 4'd8
    } mainState_t;

    // Byte sender states (UART start/guard/wait handshake)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GO    = 2'd1,
        S_GUARD = 2'd2,
        S_WAIT  = 2'd3
    } sendState_t;

    // Byte idx (0 = least significant) of a length field
    function automatic logic [7:0] fieldByte(input logic [31:0] v, input logic [1:0] idx);
        return v[{idx, 3'b000} +: 8];
    endfunction

    // Trailer value that makes payload sum + trailer == 0 mod 256
    function automatic logic [7:0] negSum(input logic [7:0] s);
        return 8'(8'd0 - s);
    endfunction

endpackage

// File: rtl/rs_tx_framer_if.sv
// rs_tx_framer_if: frame control, upstream payload stream and UART handshake.
// master = framer side, slave = sequencer/upstream/UART side.
interface rs_tx_framer_if #(parameter int LEN_W = 24);
    logic             start;
    logic [LEN_W-1:0] length;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             rs_tx_start;
    logic [7:0]       rs_tx_data;
    logic             rs_tx_status;

    modport master (
        input  start, length, in_valid, in_data, rs_tx_status,
        output busy, done, in_ready, rs_tx_start, rs_tx_data
    );

    modport slave (
        output start, length, in_valid, in_data, rs_tx_status,
        input  busy, done, in_ready, rs_tx_start, rs_tx_data
    );
endinterface

// File: rtl/rs_tx_byte_ctl.sv
// rs_tx_byte_ctl: hands one byte at a time to the UART. A send request in
// S_IDLE latches the byte, pulses txStart for one cycle, skips one cycle of
// txStatus (the UART may not have raised busy yet) and then waits for idle.
module rs_tx_byte_ctl
    import rs_tx_framer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sendReq,
    input  logic [7:0] sendData,
    output logic       senderIdle,
    output logic       senderFinishing,
    output logic       txStart,
    output logic [7:0] txData,
    input  logic       txStatus
);

    sendState_t state_r;
    logic       txStart_r;
    logic [7:0] txData_r;

    // Sender handshake FSM with registered start pulse and data holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            txStart_r <= 1'b0;
            txData_r  <= 8'h00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sendReq) begin
                        txData_r  <= sendData;
                        txStart_r <= 1'b1;
                        state_r   <= S_GO;
                    end else begin
                        txStart_r <= 1'b0;
                    end
                end
                S_GO: begin
                    txStart_r <= 1'b0;
                    state_r   <= S_GUARD;
                end
                S_GUARD: begin
                    txStart_r <= 1'b0;
                    state_r   <= S_WAIT;
                end
                S_WAIT: begin
                    txStart_r <= 1'b0;
                    if (!txStatus) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    txStart_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    assign senderIdle      = (state_r == S_IDLE);
    assign senderFinishing = (state_r == S_WAIT) && !txStatus;
    assign txStart         = txStart_r;
    assign txData          = txData_r;

endmodule

// File: rtl/rs_tx_framer.sv
// rs_tx_framer: emits SYNC0 SYNC1 LEN[23:16] LEN[15:8] LEN[7:0], then `length`
// payload bytes pulled from the upstream stream, then (when
// RS_TX_FRAMER_CKSUM_EN is defined) a trailer making the payload sum zero mod 256.
module rs_tx_framer
    import rs_tx_framer_pkg::*;
#(
    parameter logic [7:0] SYNC0 = SYNC0_DEF,
    parameter logic [7:0] SYNC1 = SYNC1_DEF,
    parameter int         LEN_W = LEN_W_DEF
)(
    input  logic          clk,
    input  logic          reset,
    rs_tx_framer_if.master bus
);

`ifdef RS_TX_FRAMER_CKSUM_EN
    localparam mainState_t AFTER_PAY = CKS;
`else
    localparam mainState_t AFTER_PAY = FIN;
`endif

    mainState_t       state_r;
    logic [LEN_W-1:0] count_r;
    logic             busy_r;
    logic             done_r;
`ifdef RS_TX_FRAMER_CKSUM_EN
    logic [7:0]       sum_r;
`endif

    logic             sendReq_s;
    logic [7:0]       sendData_s;
    logic             inReady_s;
    logic             senderIdle_s;
    logic             senderFinishing_s;
    logic [31:0]      lenExt_s;
    logic             countZero_s;

    // The counter is untouched until PAY, so it doubles as the header length source
    assign lenExt_s    = 32'(count_r);
    assign countZero_s = (count_r == {LEN_W{1'b0}});

    // Byte offered to the sender in the current state
    always_comb begin
        sendReq_s  = 1'b0;
        sendData_s = 8'h00;
        inReady_s  = 1'b0;
        case (state_r)
            HDR0: begin
                sendReq_s  = senderIdle_s;
                sendData_s = SYNC0;
            end
            HDR1: begin
                sendReq_s  = senderIdle_s;
                sendData_s = SYNC1;
            end
            LEN2: begin
                sendReq_s  = senderIdle_s;
                sendData_s = fieldByte(lenExt_s, 2'd2);
            end
            LEN1: begin
                sendReq_s  = senderIdle_s;
                sendData_s = fieldByte(lenExt_s, 2'd1);
            end
            LEN0: begin
                sendReq_s  = senderIdle_s;
                sendData_s = fieldByte(lenExt_s, 2'd0);
            end
            PAY: begin
                inReady_s  = senderIdle_s && !countZero_s;
                sendReq_s  = senderIdle_s && !countZero_s && bus.in_valid;
                sendData_s = bus.in_data;
            end
`ifdef RS_TX_FRAMER_CKSUM_EN
            CKS: begin
                sendReq_s  = senderIdle_s;
                sendData_s = negSum(sum_r);
            end
`endif
            default: begin
                sendReq_s  = 1'b0;
                sendData_s = 8'h00;
                inReady_s  = 1'b0;
            end
        endcase
    end

    // Frame sequencer: header, length, payload, optional trailer, completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            count_r <= {LEN_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef RS_TX_FRAMER_CKSUM_EN
            sum_r   <= 8'h00;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        count_r <= bus.length;
                        busy_r  <= 1'b1;
                        state_r <= HDR0;
`ifdef RS_TX_FRAMER_CKSUM_EN
                        sum_r   <= 8'h00;
`endif
                    end
                end
                HDR0: if (senderIdle_s) state_r <= HDR1;
                HDR1: if (senderIdle_s) state_r <= LEN2;
                LEN2: if (senderIdle_s) state_r <= LEN1;
                LEN1: if (senderIdle_s) state_r <= LEN0;
                LEN0: begin
                    if (senderIdle_s) begin
                        state_r <= countZero_s ? AFTER_PAY : PAY;
                    end
                end
                PAY: begin
                    if (countZero_s) begin
                        state_r <= AFTER_PAY;
                    end else if (sendReq_s) begin
                        count_r <= count_r - LEN_W'(1);
`ifdef RS_TX_FRAMER_CKSUM_EN
                        sum_r   <= sum_r + bus.in_data;
`endif
                    end
                end
`ifdef RS_TX_FRAMER_CKSUM_EN
                CKS: if (senderIdle_s) state_r <= FIN;
`endif
                FIN: begin
                    // Finish in the cycle the UART is seen idle, not one later
                    if (senderIdle_s || senderFinishing_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    rs_tx_byte_ctl u_byteCtl (
        .clk             (clk),
        .reset           (reset),
        .sendReq         (sendReq_s),
        .sendData        (sendData_s),
        .senderIdle      (senderIdle_s),
        .senderFinishing (senderFinishing_s),
        .txStart         (bus.rs_tx_start),
        .txData          (bus.rs_tx_data),
        .txStatus        (bus.rs_tx_status)
    );

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.in_ready = inReady_s;

endmodule
